aes_output_buffer: RTL
======================

// Module: aes_output_buffer
// PURPOSE
//  Downstream stage of the AES encryption pipeline. Captures each finished 128-bit
//  ciphertext block (data_done/data_output), queues it in a DEPTH-entry FIFO, and
//  streams it out as four 32-bit words over a valid/ready interface. Drives the
//  pipeline's is_full stall input so that no finished block is lost or duplicated.
// PARAMETERS
//  DEPTH   4   FIFO entries (128-bit blocks); power of two, >= 2
// PORTS
//  clk             in   1    system clock, all logic on rising edge
//  rst             in   1    reset, asynchronous, active-high
//  i_data_done     in   1    encryption pipeline: finished block present
//  i_data          in   128  encryption pipeline: finished ciphertext block
//  o_is_full       out  1    stall to encryption pipeline (its is_full input)
//  o_word          out  32   output word
//  o_word_valid    out  1    o_word is valid
//  i_word_ready    in   1    downstream accepts o_word this cycle
//  o_block_last    out  1    current o_word is word 3 (last) of its block
//  o_empty         out  1    FIFO empty and serializer idle
// BEHAVIOUR
//  - Reset (async, any time incl. mid-block): FIFO pointers/count = 0, serializer
//    IDLE, o_word = 0, o_word_valid = 0, o_block_last = 0, o_is_full = 0, o_empty = 1.
//    Partially sent block is discarded.
//  - Push: on clk edge when i_data_done && !o_is_full -> i_data written at wr_ptr.
//    Pipeline holds data_done high while stalled; since push is gated by o_is_full,
//    each block is captured exactly once (on the cycle o_is_full is low).
//  - o_is_full = (count == DEPTH), from registered count only (no comb path from
//    i_data_done or i_word_ready).
//  - Pointers log2(DEPTH) bits, wrap DEPTH-1 -> 0; count log2(DEPTH)+1 bits.
//  - Serializer FSM, 128-bit shift register + 2-bit word index:
//    IDLE: if count > 0 -> pop head into shift reg, idx = 0, go SEND.
//    SEND: o_word_valid = 1, o_word = shreg[127-32*idx -: 32] (MSW first).
//      valid && !ready -> hold o_word, idx stable.
//      valid && ready && idx < 3 -> idx++.
//      valid && ready && idx == 3 -> if count > 0 pop next block, idx = 0, stay
//      SEND (no bubble between blocks); else go IDLE.
//  - o_block_last = o_word_valid && idx == 3.
//  - Latency: block pushed at edge N into empty buffer -> popped at edge N+1 ->
//    word 0 valid in cycle after N+1; with ready held high, words on 4 consecutive
//    cycles.
//  - Simultaneous push and pop: count unchanged; pop uses pre-edge head, push
//    writes wr_ptr; legal when count == DEPTH-1 (no push when count == DEPTH).
//  - Capacity: DEPTH blocks in FIFO + 1 in serializer before stall.
//  - o_empty = (count == 0) && IDLE.
// CONFIGURATION
//  AES_OBUF_BYTE_SWAP_EN defined: o_word byte order reversed within each word
//    (o_word = {w[7:0],w[15:8],w[23:16],w[31:24]}) for little-endian consumers.
//  Not defined: o_word is the slice unchanged (big-endian, MSB first).
// TESTING (DEPTH = 4, macro undefined unless stated)
//  1 Reset asserted mid-SEND -> same cycle o_word_valid=0, o_is_full=0, o_empty=1;
//    after release no stale words emitted.
//  2 Push 0x00112233_44556677_8899AABB_CCDDEEFF, ready=1 -> words 00112233,
//    44556677, 8899AABB, CCDDEEFF on 4 consecutive cycles, o_block_last on 4th only.
//  3 ready=0, push 5 blocks -> o_is_full rises after 5th; data_done held 3 cycles
//    not captured; raise ready -> that block captured exactly once, 24 words total
//    in order.
//  4 ready toggles 1,0,0,1,... mid-block -> o_word stable while valid && !ready,
//    no word skipped or repeated.
//  5 Two blocks pushed back-to-back, ready=1 -> 8 consecutive valid cycles, no
//    bubble; push during final pop at count=3 -> count stays 3.
//  6 AES_OBUF_BYTE_SWAP_EN defined, block of test 2 -> first word 0x33221100,
//    last word 0xFFEEDDCC.

Source files
------------

// File: rtl/aes_output_buffer_if.sv
// aes_output_buffer_if: block capture and word stream signals of the AES output buffer
//   slave  : buffer side (takes blocks, drives words)
//   master : environment side (drives blocks, takes words)
interface aes_output_buffer_if;
  logic         i_data_done;
  logic [127:0] i_data;
  logic         o_is_full;
  logic [31:0]  o_word;
  logic         o_word_valid;
  logic         i_word_ready;
  logic         o_block_last;
  logic         o_empty;
  modport slave (
    input  i_data_done, i_data, i_word_ready,
    output o_is_full, o_word, o_word_valid, o_block_last, o_empty
  );
  modport master (
    output i_data_done, i_data, i_word_ready,
    input  o_is_full, o_word, o_word_valid, o_block_last, o_empty
  );
endinterface

// File: rtl/aes_output_buffer.sv
// aes_output_buffer: DEPTH-block FIFO of 128-bit ciphertext streamed out as four 32-bit words
//   clk, rst (async, active-high); bus.slave carries block capture (i_data_done/i_data/o_is_full)
//   and word stream (o_word/o_word_valid/i_word_ready/o_block_last) plus o_empty.
//   AES_OBUF_BYTE_SWAP_EN: reverse byte order within each output word.
module aes_output_buffer #(
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  aes_output_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_n;
  logic [127:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [3:0][31:0] shreg;
  logic [1:0] idx;
  logic push, pop, nonempty, last_taken;
  logic [31:0] w;
  assign nonempty = count != '0;
  assign push = bus.i_data_done && !bus.o_is_full;
  assign last_taken = state == SEND && bus.i_word_ready && idx == 2'd3;
  // Popping straight out of the final word keeps blocks back-to-back with no bubble
  always_comb begin
    pop = nonempty && (state == IDLE || last_taken);
    state_n = state == IDLE ? (nonempty ? SEND : IDLE) : (last_taken && !nonempty ? IDLE : SEND);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      shreg <= '0;
      idx <= '0;
    end else begin
      state <= state_n;
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      if (pop) begin
        shreg <= mem[rd_ptr];
        idx <= '0;
      end else if (state == SEND && bus.i_word_ready) idx <= idx + 2'd1;
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.i_data;
  // ~idx selects word 3-idx, i.e. most significant word first
  assign w = bus.o_word_valid ? shreg[~idx] : 32'h0;
`ifdef AES_OBUF_BYTE_SWAP_EN
  assign bus.o_word = {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
  assign bus.o_word = w;
`endif
  assign bus.o_word_valid = state == SEND;
  assign bus.o_block_last = bus.o_word_valid && idx == 2'd3;
  assign bus.o_is_full = count == FULL;
  assign bus.o_empty = !nonempty && state == IDLE;
endmodule
